seg_scan_monitor: RTL and testbench

- Receive-side decoder for the multiplexed 6-digit, 7-segment display bus driven by the display scanner.
- Watches `seg_data`/`seg_cs`, waits for each digit's segment pattern to settle, and decodes it back to the 5-bit-per-digit display code.
- Assembles a full 30-bit frame and publishes it with a one-cycle strobe.
- Sits beside the display pins as an on-chip monitor and self-check for the top-level display logic, and as a reusable bench checker.

---
 rtl/seg_scan_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_seg_scan_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_monitor.sv
// Decodes a multiplexed 6-digit 7-segment bus back into 5-bit digit codes and publishes whole frames.
// Define SEGMON_DP_EN to capture and publish the decimal-point bit (seg_data[7]) per digit.
module seg_scan_monitor #(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_data,
  input  logic [5:0]  seg_cs,
  output logic [29:0] frame,
  output logic [5:0]  dp,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        err,
  output logic        stale
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef SEGMON_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
  logic unused_dp_bit;
  assign unused_dp_bit = seg_data[7];
`endif

  typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_t;

  logic [SEG_W-1:0] seg_reg, seg_prev_reg;
  logic [5:0]       cs_reg, cs_prev_reg;
  logic [SW-1:0]    stab_reg, stab_next;
  logic [TW-1:0]    to_cnt_reg;
  logic [2:0]       low_cnt, slot;
  logic             single_low, multi_low, same_sample, capture, bad_code;
  logic [4:0]       code;
  logic [5:0]       slot_we;
  logic [29:0]      shadow_reg, frame_reg;
  logic [5:0]       mask_reg, mask_next;
  state_t           state_reg, state_next;
  logic             valid_reg, changed_reg, err_reg, first_reg, frame_diff;

  // Input stage: every decision below uses these registered copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg      <= '0;
      seg_prev_reg <= '0;
      cs_reg       <= '1;
      cs_prev_reg  <= '1;
    end else begin
      seg_reg      <= seg_data[SEG_W-1:0];
      seg_prev_reg <= seg_reg;
      cs_reg       <= seg_cs;
      cs_prev_reg  <= cs_reg;
    end
  end

  always_comb begin
    low_cnt = '0;
    slot    = '0;
    for (int i = 0; i < 6; i++) begin
      if (!cs_reg[i]) begin
        low_cnt = low_cnt + 3'd1;
        slot    = 3'(i);
      end
    end
  end

  assign single_low  = (low_cnt == 3'd1);
  assign multi_low   = (low_cnt >= 3'd2);
  assign same_sample = (cs_reg == cs_prev_reg) && (seg_reg == seg_prev_reg);

  always_comb begin
    stab_next = '0;
    if (single_low) begin
      if (!same_sample)
        stab_next = SW'(1);
      else if (stab_reg == SW'(STABLE_CYC))
        stab_next = stab_reg;
      else
        stab_next = stab_reg + SW'(1);
    end
  end

  // Fires only on the transition into the saturated count, so once per dwell.
  assign capture = single_low && (stab_next == SW'(STABLE_CYC)) && (stab_reg != SW'(STABLE_CYC));

  always_comb begin
    unique case (~seg_reg[6:0])
      7'h3F: code = 5'h00;
      7'h06: code = 5'h01;
      7'h5B: code = 5'h02;
      7'h4F: code = 5'h03;
      7'h66: code = 5'h04;
      7'h6D: code = 5'h05;
      7'h7D: code = 5'h06;
      7'h07: code = 5'h07;
      7'h7F: code = 5'h08;
      7'h6F: code = 5'h09;
      7'h77: code = 5'h0A;
      7'h7C: code = 5'h0B;
      7'h39: code = 5'h0C;
      7'h5E: code = 5'h0D;
      7'h79: code = 5'h0E;
      7'h71: code = 5'h0F;
      7'h00: code = 5'h10;
      default: code = 5'h1F;
    endcase
  end
  assign bad_code = (code == 5'h1F);

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_slot_we
      assign slot_we[gi] = capture && (slot == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg <= '0;
    end else begin
      for (int i = 0; i < 6; i++)
        if (slot_we[i]) shadow_reg[i*5 +: 5] <= code;
    end
  end

  // A capture during PUBLISH lands in the freshly cleared mask.
  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    case (state_reg)
      IDLE: begin
        if (capture) begin
          mask_next  = slot_we;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        mask_next = mask_reg | slot_we;
        if (mask_next == 6'h3F) state_next = PUBLISH;
      end
      PUBLISH: begin
        mask_next  = slot_we;
        state_next = COLLECT;
      end
      default: begin
        mask_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

`ifdef SEGMON_DP_EN
  logic [5:0] shadow_dp_reg, dp_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_dp_reg <= '0;
      dp_reg        <= '0;
    end else begin
      for (int i = 0; i < 6; i++)
        if (slot_we[i]) shadow_dp_reg[i] <= ~seg_reg[7];
      if (state_reg == PUBLISH) dp_reg <= shadow_dp_reg;
    end
  end
  assign frame_diff = (shadow_reg != frame_reg) || (shadow_dp_reg != dp_reg);
  assign dp         = dp_reg;
`else
  assign frame_diff = (shadow_reg != frame_reg);
  assign dp         = 6'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mask_reg    <= '0;
      stab_reg    <= '0;
      to_cnt_reg  <= '0;
      frame_reg   <= '0;
      valid_reg   <= 1'b0;
      changed_reg <= 1'b0;
      err_reg     <= 1'b0;
      first_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      stab_reg    <= stab_next;
      valid_reg   <= 1'b0;
      changed_reg <= 1'b0;
      err_reg     <= err_reg | multi_low | (capture & bad_code);
      if (capture)
        to_cnt_reg <= '0;
      else if (to_cnt_reg != TW'(TIMEOUT_CYC))
        to_cnt_reg <= to_cnt_reg + TW'(1);
      if (state_reg == PUBLISH) begin
        frame_reg   <= shadow_reg;
        valid_reg   <= 1'b1;
        changed_reg <= first_reg | frame_diff;
        first_reg   <= 1'b0;
      end
    end
  end

  assign frame         = frame_reg;
  assign frame_valid   = valid_reg;
  assign frame_changed = changed_reg;
  assign err           = err_reg;
  assign stale         = (to_cnt_reg == TW'(TIMEOUT_CYC));

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Directed self-checking bench for seg_scan_monitor (STABLE_CYC=16, TIMEOUT_CYC=64).
module tb_seg_scan_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_data;
  logic [5:0]  seg_cs;
  logic [29:0] frame;
  logic [5:0]  dp;
  logic        frame_valid, frame_changed, err, stale;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int changed_cnt = 0;
  int v0, c0;

  seg_scan_monitor #(.STABLE_CYC(16), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .seg_data(seg_data), .seg_cs(seg_cs),
    .frame(frame), .dp(dp), .frame_valid(frame_valid), .frame_changed(frame_changed),
    .err(err), .stale(stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      valid_cnt++;
      if (frame_changed === 1'b1) changed_cnt++;
      $display("frame_valid frame=%h dp=%h changed=%0b", frame, dp, frame_changed);
    end
  end

  task automatic dwell(input logic [5:0] cs, input logic [7:0] sg, input int n);
    seg_cs   = cs;
    seg_data = sg;
    repeat (n) @(negedge clk);
  endtask

  task automatic gap(input int n);
    dwell(6'h3F, 8'hFF, n);
  endtask

  // segs[47:40] is digit 5 (leftmost) ... segs[7:0] is digit 0
  task automatic scan6(input logic [47:0] segs);
    logic [47:0] s;
    s = segs;
    $display("scan segs=%h", s);
    for (int d = 5; d >= 0; d--) begin
      logic [5:0] cs;
      cs = 6'h3F;
      cs[d] = 1'b0;
      dwell(cs, s[d*8 +: 8], 20);
    end
    gap(4);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    seg_cs = 6'h3F;
    seg_data = 8'hFF;
    repeat (3) @(negedge clk);
    checks++; if (frame !== 30'h0) begin errors++; $display("FAIL reset_frame: got %h expected %h", frame, 30'h0); end
    checks++; if (dp !== 6'h0) begin errors++; $display("FAIL reset_dp: got %h expected 00", dp); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    checks++; if (frame_changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b expected 0", frame_changed); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL reset_stale: got %b expected 0", stale); end
    rst = 1'b0;
    gap(2);
  endtask

  task automatic test_scan;
    v0 = valid_cnt; c0 = changed_cnt;
    scan6(48'hB0B099C0F980);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL scan_valid_count: got %0d expected 1", valid_cnt - v0); end
    checks++; if (frame !== 30'h06320028) begin errors++; $display("FAIL scan_frame: got %h expected 06320028", frame); end
    checks++; if (changed_cnt - c0 !== 1) begin errors++; $display("FAIL scan_changed: got %0d expected 1", changed_cnt - c0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL scan_err: got %b expected 0", err); end
  endtask

  task automatic test_back_to_back;
    v0 = valid_cnt; c0 = changed_cnt;
    scan6(48'hB0B099C0F980);
    scan6(48'hB0B099C0F980);
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL repeat_valid_count: got %0d expected 2", valid_cnt - v0); end
    checks++; if (changed_cnt - c0 !== 0) begin errors++; $display("FAIL repeat_changed: got %0d expected 0", changed_cnt - c0); end
    checks++; if (frame !== 30'h06320028) begin errors++; $display("FAIL repeat_frame: got %h expected 06320028", frame); end
  endtask

  task automatic test_short_dwell;
    v0 = valid_cnt; c0 = changed_cnt;
    $display("short dwell on digit 3");
    dwell(6'h1F, 8'hB0, 20);
    dwell(6'h2F, 8'hB0, 20);
    dwell(6'h37, 8'h99, 10);
    dwell(6'h3B, 8'hC0, 20);
    dwell(6'h3D, 8'hF9, 20);
    dwell(6'h3E, 8'h80, 20);
    gap(4);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL short_no_valid: got %0d expected 0", valid_cnt - v0); end
    dwell(6'h37, 8'hF8, 20);
    gap(4);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL short_then_full_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (frame !== 30'h06338028) begin errors++; $display("FAIL short_frame: got %h expected 06338028", frame); end
    checks++; if (changed_cnt - c0 !== 1) begin errors++; $display("FAIL short_changed: got %0d expected 1", changed_cnt - c0); end
  endtask

  task automatic test_decode;
    v0 = valid_cnt;
    scan6(48'hB0B099C0F900);
    checks++; if (frame !== 30'h06320028) begin errors++; $display("FAIL decode_eight_frame: got %h expected 06320028", frame); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL decode_eight_err: got %b expected 0", err); end
    checks++; if (dp !== 6'h00) begin errors++; $display("FAIL decode_dp_tied: got %h expected 00", dp); end
    scan6(48'hB0B099C0F955);
    checks++; if (frame !== 30'h0632003F) begin errors++; $display("FAIL decode_bad_frame: got %h expected 0632003F", frame); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL decode_bad_err: got %b expected 1", err); end
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL decode_valid_count: got %0d expected 2", valid_cnt - v0); end
  endtask

  task automatic test_multi_cs;
    rst = 1'b1;
    gap(2);
    rst = 1'b0;
    gap(2);
    v0 = valid_cnt;
    $display("multi cs 3C");
    dwell(6'h3C, 8'hC0, 20);
    gap(4);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL multi_err_set: got %b expected 1", err); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL multi_no_valid: got %0d expected 0", valid_cnt - v0); end
    scan6(48'hB0B099C0F980);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL multi_recover_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (frame !== 30'h06320028) begin errors++; $display("FAIL multi_recover_frame: got %h expected 06320028", frame); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL multi_err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_reset_mid;
    $display("reset after three captures");
    dwell(6'h1F, 8'hB0, 20);
    dwell(6'h2F, 8'hB0, 20);
    dwell(6'h37, 8'h99, 20);
    rst = 1'b1;
    gap(2);
    rst = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_reset_err: got %b expected 0", err); end
    checks++; if (frame !== 30'h0) begin errors++; $display("FAIL mid_reset_frame: got %h expected 0", frame); end
    v0 = valid_cnt; c0 = changed_cnt;
    dwell(6'h3B, 8'hC0, 20);
    dwell(6'h3D, 8'hF9, 20);
    dwell(6'h3E, 8'h80, 20);
    gap(4);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL mid_partial_discarded: got %0d expected 0", valid_cnt - v0); end
    dwell(6'h1F, 8'hB0, 20);
    dwell(6'h2F, 8'hB0, 20);
    dwell(6'h37, 8'h99, 20);
    gap(4);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL mid_valid_count: got %0d expected 1", valid_cnt - v0); end
    checks++; if (frame !== 30'h06320028) begin errors++; $display("FAIL mid_frame: got %h expected 06320028", frame); end
    checks++; if (changed_cnt - c0 !== 1) begin errors++; $display("FAIL mid_first_changed: got %0d expected 1", changed_cnt - c0); end
  endtask

  task automatic test_stale;
    $display("idle for stale timeout");
    gap(30);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_early: got %b expected 0", stale); end
    gap(40);
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL stale_set: got %b expected 1", stale); end
    dwell(6'h3E, 8'h80, 20);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_cleared: got %b expected 0", stale); end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_back_to_back;
    test_short_dwell;
    test_decode;
    test_multi_cs;
    test_reset_mid;
    test_stale;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
